// File: rtl/param_menu_if.sv
// Front-panel button inputs and display/field outputs of the parameter menu.
interface param_menu_if #(
   parameter int NUM_FIELDS  = 8,
   parameter int FIELD_W     = 5,
   parameter int DISP_DIGITS = 16
);
   localparam int CW = $clog2(NUM_FIELDS + 1);
   localparam int IW = $clog2(NUM_FIELDS);

   logic                          blink_fo;
   logic                          b_up;
   logic                          b_down;
   logic                          b_right;
   logic                          b_left;
   logic                          lock;
   logic [DISP_DIGITS-1:0]        blink_fo_data;
   logic [NUM_FIELDS*FIELD_W-1:0] field_vals;
   logic [CW-1:0]                 cursor;
   logic                          changed;
   logic [IW-1:0]                 changed_idx;

   modport master (
      output blink_fo, b_up, b_down, b_right, b_left, lock,
      input  blink_fo_data, field_vals, cursor, changed, changed_idx
   );

   modport slave (
      input  blink_fo, b_up, b_down, b_right, b_left, lock,
      output blink_fo_data, field_vals, cursor, changed, changed_idx
   );
endinterface

// File: rtl/param_menu.sv
// Front-panel parameter menu: cursor over N fields, up/down edit with wrap or saturate.
// Optional hold-to-repeat editing is built when PARAM_MENU_AUTOREPEAT_EN is defined.
module param_menu #(
   parameter int                                 NUM_FIELDS   = 8,
   parameter int                                 FIELD_W      = 5,
   parameter logic [NUM_FIELDS*FIELD_W-1:0]      FIELD_MAX    = {5'd15, 5'd7, 5'd3, 5'd3,
                                                                 5'd31, 5'd31, 5'd11, 5'd1},
   parameter logic [NUM_FIELDS*FIELD_W-1:0]      FIELD_RST    = {35'd0, 5'd1},
   parameter logic [NUM_FIELDS-1:0]              WRAP_MASK    = 8'hFF,
   parameter int                                 DISP_DIGITS  = 16,
   parameter logic [NUM_FIELDS*DISP_DIGITS-1:0]  FIELD_DIGITS = {16'h8000, 16'h0001, 16'h0002, 16'h0004,
                                                                 16'h0018, 16'h0060, 16'h0100, 16'h0400},
   parameter int                                 REPEAT_DELAY = 25_000_000,
   parameter int                                 REPEAT_RATE  = 5_000_000
) (
   input logic          clk,
   input logic          reset,
   param_menu_if.slave  bus
);
   localparam int              CW   = $clog2(NUM_FIELDS + 1);
   localparam int              IW   = $clog2(NUM_FIELDS);
   localparam logic [CW-1:0]   LAST = CW'(NUM_FIELDS);

   // Button vectors are ordered {right, left, up, down}.
   logic [3:0]                    btn_q, btn_d, prev_q, prev_d, ev;
   logic [CW-1:0]                 cursor_q, cursor_d;
   logic [NUM_FIELDS*FIELD_W-1:0] vals_q, vals_d;
   logic [DISP_DIGITS-1:0]        blink_q, blink_d;
   logic                          changed_q, changed_d;
   logic [IW-1:0]                 idx_q, idx_d;

   logic [IW-1:0]      f;
   logic [FIELD_W-1:0] v, v_max, v_new;
   logic               wrap, step_up, step_dn;
   logic               rpt_fire, rpt_dn;

   assign ev = btn_q & ~prev_q;
   assign f  = IW'(cursor_q - CW'(1));

`ifdef PARAM_MENU_AUTOREPEAT_EN
   localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);

   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          rpt_act_q, rpt_act_d, rpt_dn_q, rpt_dn_d;

   always_comb begin
      rpt_cnt_d = rpt_cnt_q;
      rpt_act_d = rpt_act_q;
      rpt_dn_d  = rpt_dn_q;
      rpt_fire  = 1'b0;
      if (ev[3] || ev[2] || (btn_q[1] && btn_q[0])) begin
         rpt_act_d = 1'b0;
      end else if (ev[1] || ev[0]) begin
         rpt_act_d = 1'b1;
         rpt_dn_d  = ~ev[1];
         rpt_cnt_d = RW'(REPEAT_DELAY - 1);
      end else if (rpt_act_q && (rpt_dn_q ? btn_q[0] : btn_q[1])) begin
         if (rpt_cnt_q == '0) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = RW'(REPEAT_RATE - 1);
         end else begin
            rpt_cnt_d = rpt_cnt_q - 1'b1;
         end
      end else begin
         rpt_act_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rpt_cnt_q <= '0;
         rpt_act_q <= 1'b0;
         rpt_dn_q  <= 1'b0;
      end else begin
         rpt_cnt_q <= rpt_cnt_d;
         rpt_act_q <= rpt_act_d;
         rpt_dn_q  <= rpt_dn_d;
      end
   end

   assign rpt_dn = rpt_dn_q;
`else
   logic unused_rpt;
   assign unused_rpt = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
   assign rpt_fire   = 1'b0;
   assign rpt_dn     = 1'b0;
`endif

   always_comb begin
      btn_d     = {bus.b_right, bus.b_left, bus.b_up, bus.b_down};
      prev_d    = btn_q;
      cursor_d  = cursor_q;
      vals_d    = vals_q;
      changed_d = 1'b0;
      idx_d     = idx_q;
      step_up   = 1'b0;
      step_dn   = 1'b0;
      v         = vals_q[f*FIELD_W +: FIELD_W];
      v_max     = FIELD_MAX[f*FIELD_W +: FIELD_W];
      wrap      = WRAP_MASK[f];
      v_new     = v;
      // Blink follows the cursor already registered, so it trails a move by one cycle.
      blink_d   = (cursor_q == '0) ? '0
                : FIELD_DIGITS[f*DISP_DIGITS +: DISP_DIGITS] & {DISP_DIGITS{bus.blink_fo}};

      if (ev[3]) begin
         cursor_d = (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
      end else if (ev[2]) begin
         cursor_d = (cursor_q == '0) ? LAST : cursor_q - 1'b1;
      end else if ((cursor_q != '0) && !bus.lock) begin
         step_up = ev[1] | (rpt_fire & ~rpt_dn);
         step_dn = ~ev[1] & (ev[0] | (rpt_fire & rpt_dn));
      end

      if (step_up) begin
         v_new = (v < v_max) ? v + 1'b1 : (wrap ? '0 : v);
      end else if (step_dn) begin
         v_new = (v != '0) ? v - 1'b1 : (wrap ? v_max : v);
      end

      if (v_new != v) begin
         vals_d[f*FIELD_W +: FIELD_W] = v_new;
         changed_d                    = 1'b1;
         idx_d                        = f;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q     <= btn_d;
         prev_q    <= btn_d;
         cursor_q  <= '0;
         vals_q    <= FIELD_RST;
         blink_q   <= '0;
         changed_q <= 1'b0;
         idx_q     <= '0;
      end else begin
         btn_q     <= btn_d;
         prev_q    <= prev_d;
         cursor_q  <= cursor_d;
         vals_q    <= vals_d;
         blink_q   <= blink_d;
         changed_q <= changed_d;
         idx_q     <= idx_d;
      end
   end

   assign bus.blink_fo_data = blink_q;
   assign bus.field_vals    = vals_q;
   assign bus.cursor        = cursor_q;
   assign bus.changed       = changed_q;
   assign bus.changed_idx   = idx_q;
endmodule

// File: tb/tb_param_menu.sv
// Self-checking bench for param_menu: table of button actions with expected menu state,
// queued as a scoreboard and compared once the outputs have settled.
module tb_param_menu;
   localparam int NF = 8;
   localparam int FW = 5;
   localparam int DD = 16;

   typedef enum int {A_NONE, A_R, A_L, A_U, A_D, A_RU} act_e;

   typedef struct {
      act_e        act;
      logic        lock;
      logic        bf;
      logic [3:0]  cur;
      int          fidx;
      logic [4:0]  fval;
      logic        ch;
      logic [2:0]  idx;
      logic [15:0] blink;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulses = 0;
   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   param_menu_if #(.NUM_FIELDS(NF), .FIELD_W(FW), .DISP_DIGITS(DD)) bus ();

   param_menu #(
      .WRAP_MASK(8'hEF)
`ifdef PARAM_MENU_AUTOREPEAT_EN
      , .REPEAT_DELAY(4), .REPEAT_RATE(2)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always @(negedge clk) if (!reset && bus.changed) pulses++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input act_e a, input logic lk, input logic bf, input int cur,
                               input int fidx, input int fval, input logic ch, input int idx,
                               input logic [15:0] bl);
      vec_t r;
      r.act = a;   r.lock = lk;  r.bf = bf;  r.cur = 4'(cur);
      r.fidx = fidx; r.fval = 5'(fval); r.ch = ch; r.idx = 3'(idx); r.blink = bl;
      return r;
   endfunction

   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge clk);
      bus.lock     = v.lock;
      bus.blink_fo = v.bf;
      case (v.act)
         A_R:  bus.b_right = 1'b1;
         A_L:  bus.b_left  = 1'b1;
         A_U:  bus.b_up    = 1'b1;
         A_D:  bus.b_down  = 1'b1;
         A_RU: begin bus.b_right = 1'b1; bus.b_up = 1'b1; end
         default: ;
      endcase
      sb.push_back(v);
      @(negedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check("cursor",      64'(bus.cursor), 64'(e.cur));
      check("field_val",   64'(bus.field_vals[e.fidx*FW +: FW]), 64'(e.fval));
      check("changed",     64'(bus.changed), 64'(e.ch));
      check("changed_idx", 64'(bus.changed_idx), 64'(e.idx));
      bus.b_right = 1'b0; bus.b_left = 1'b0; bus.b_up = 1'b0; bus.b_down = 1'b0;
      @(negedge clk);
      check("blink_mask",  64'(bus.blink_fo_data), 64'(e.blink));
      check("changed_one_cycle", 64'(bus.changed), 64'(0));
   endtask

   initial begin
`ifdef PARAM_MENU_AUTOREPEAT_EN
      int base;
`endif
      // cursor moves and idle edits
      tbl.push_back(mk(A_L, 0, 1, 8, 7, 0, 0, 0, 16'h8000));
      tbl.push_back(mk(A_R, 0, 1, 0, 0, 1, 0, 0, 16'h0000));
      tbl.push_back(mk(A_U, 0, 1, 0, 0, 1, 0, 0, 16'h0000));
      tbl.push_back(mk(A_R, 0, 1, 1, 0, 1, 0, 0, 16'h0400));
      tbl.push_back(mk(A_R, 0, 0, 2, 1, 0, 0, 0, 16'h0000));
      // field1 (max 11, wraps): 12 ups end back at 0
      for (int i = 0; i < 12; i++)
         tbl.push_back(mk(A_U, 0, 1, 2, 1, (i < 11) ? i + 1 : 0, 1, 1, 16'h0100));
      // simultaneous right+up, lock, wrap-down from 0
      tbl.push_back(mk(A_RU, 0, 0, 3, 2, 0, 0, 1, 16'h0000));
      tbl.push_back(mk(A_U,  1, 1, 3, 2, 0, 0, 1, 16'h0060));
      tbl.push_back(mk(A_D,  0, 1, 3, 2, 31, 1, 2, 16'h0060));
      tbl.push_back(mk(A_R,  0, 0, 4, 3, 0, 0, 2, 16'h0000));
      tbl.push_back(mk(A_R,  0, 1, 5, 4, 0, 0, 2, 16'h0004));
      // field4 (max 3, saturating)
      tbl.push_back(mk(A_U, 0, 1, 5, 4, 1, 1, 4, 16'h0004));
      tbl.push_back(mk(A_U, 0, 1, 5, 4, 2, 1, 4, 16'h0004));
      tbl.push_back(mk(A_U, 0, 1, 5, 4, 3, 1, 4, 16'h0004));
      tbl.push_back(mk(A_U, 0, 1, 5, 4, 3, 0, 4, 16'h0004));
      tbl.push_back(mk(A_U, 0, 1, 5, 4, 3, 0, 4, 16'h0004));
      tbl.push_back(mk(A_D, 0, 1, 5, 4, 2, 1, 4, 16'h0004));
      tbl.push_back(mk(A_D, 0, 1, 5, 4, 1, 1, 4, 16'h0004));
      tbl.push_back(mk(A_D, 0, 1, 5, 4, 0, 1, 4, 16'h0004));
      tbl.push_back(mk(A_D, 0, 1, 5, 4, 0, 0, 4, 16'h0004));
      for (int c = 4; c >= 1; c--)
         tbl.push_back(mk(A_L, 0, 0, c, 4, 0, 0, 4, 16'h0000));
      // field0 (max 1, reset 1) wraps up to 0 then back to 1
      tbl.push_back(mk(A_U, 0, 1, 1, 0, 0, 1, 0, 16'h0400));
      tbl.push_back(mk(A_U, 0, 1, 1, 0, 1, 1, 0, 16'h0400));

      // reset with b_right held: no move once reset drops
      bus.b_up = 1'b0; bus.b_down = 1'b0; bus.b_left = 1'b0; bus.lock = 1'b0;
      bus.b_right = 1'b1; bus.blink_fo = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cursor",      64'(bus.cursor), 64'(0));
      check("rst_field_vals",  64'(bus.field_vals), 64'h1);
      check("rst_blink",       64'(bus.blink_fo_data), 64'(0));
      check("rst_changed",     64'(bus.changed), 64'(0));
      check("rst_changed_idx", 64'(bus.changed_idx), 64'(0));
      bus.b_right = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) apply(tbl[i]);

      check("final_field_vals", 64'(bus.field_vals), 64'h7C01);
      check("pulse_total",      64'(pulses), 64'(21));

`ifdef PARAM_MENU_AUTOREPEAT_EN
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 1; c <= 3; c++) apply(mk(A_R, 0, 0, c, 2, 0, 0, 0, 16'h0000));
      base = pulses;
      @(negedge clk);
      bus.b_up = 1'b1;
      repeat (10) @(negedge clk);
      bus.b_up = 1'b0;
      repeat (4) @(negedge clk);
      check("rpt_field2", 64'(bus.field_vals[2*FW +: FW]), 64'(4));
      check("rpt_pulses", 64'(pulses - base), 64'(4));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
